mop_sum_ctrl: RTL
=================

MOP_SUM_CTRL -- requirements
Module: mop_sum_ctrl

Interface
REQ-001 The block SHALL have these parameters: W, default 16, operand width; NW, default 8, operand-count width; AW, default W+NW (24), accumulator and result width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse, sampled only in IDLE
- num_ops  in  NW  operand count for the job, latched on accepted start
- clear  in  1  synchronous abort, returns to IDLE
- in_valid  in  1  operand-pair beat valid
- in_ready  out  1  block accepts a beat
- in_a  in  W  first operand of the beat
- in_b  in  W  second operand of the beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  AW  sum of all job operands, zero-extended
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on a start with num_ops==0

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-005 In IDLE, start=1 with num_ops!=0 SHALL do all of: latch rem=num_ops; clear acc to 0; go to ACC on the next edge.
REQ-006 In IDLE, start=1 with num_ops==0 SHALL pulse err for one cycle and remain in IDLE.
REQ-007 The block SHALL assert in_ready only in ACC; a beat SHALL transfer when in_valid and in_ready are both 1 on a rising edge.
REQ-008 Each transferred beat SHALL update acc to acc + in_a + in_b using one 3-operand addition per cycle, with all operands zero-extended to AW.
REQ-009 When rem==1 on a beat, in_b SHALL be ignored and treated as 0, rem SHALL become 0, and the FSM SHALL go to DONE.
REQ-010 When rem==2 on a beat, rem SHALL become 0 and the FSM SHALL go to DONE; otherwise each beat SHALL decrement rem by 2.
REQ-011 A job SHALL therefore consume exactly ceil(num_ops/2) beats.
REQ-012 AW SHALL be wide enough that the sum cannot overflow: the maximum is 255*65535 = 0xFEFF01 at the default parameters.
REQ-013 In DONE, out_valid SHALL be 1 and out_sum SHALL equal acc, held stable until out_ready=1; on out_valid and out_ready the FSM SHALL return to IDLE.
REQ-014 The first cycle of out_valid SHALL be the cycle after the last beat transfers (latency 1).
REQ-015 out_sum SHALL read 0 whenever out_valid=0.
REQ-016 start SHALL be ignored while busy=1, with no effect on rem, acc or err.
REQ-017 in_valid with no beat transfer SHALL leave acc and rem unchanged; idle-cycle gaps between beats are allowed.
REQ-018 clear=1 SHALL, from any state on the next edge, do all of: go to IDLE; zero acc and rem; deassert out_valid; discard the job with no output.
REQ-019 clear SHALL take priority over start, beat transfer and out_ready in the same cycle.
REQ-020 A new start SHALL be accepted no earlier than the cycle after the DONE->IDLE transition; back-to-back jobs therefore have at least one idle cycle.
REQ-021 All outputs SHALL be driven from registers or state decode, with no combinational path from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-022 While rst_n=0 the block SHALL force state=IDLE, acc=0, rem=0, in_ready=0, out_valid=0, out_sum=0, busy=0 and err=0, independent of clk.
REQ-023 Reset asserted mid-job SHALL abandon the job.
REQ-024 After rst_n rises, the first start SHALL be accepted on the first rising edge.

Verification
REQ-025 Scenario even count: num_ops=4, beats (0x0001,0x0002), (0x0003,0x0004) -> out_valid one cycle after the second beat, out_sum=0x00000A.
REQ-026 Scenario odd count: num_ops=3, beats (0xFFFF,0xFFFF), (0xFFFF,0x1234) -> in_b=0x1234 ignored, out_sum=0x02FFFD.
REQ-027 Scenario maximum: num_ops=255, 128 beats of all 0xFFFF -> out_sum=0xFEFF01, no overflow.
REQ-028 Scenario backpressure and gaps: in_valid toggled 1/0 between beats, then out_ready held 0 for 5 cycles -> out_sum stable while held, one job completes, start pulses during ACC ignored.
REQ-029 Scenario error and abort: start with num_ops=0 -> err high exactly 1 cycle, state stays IDLE; clear after 1 of 3 beats -> IDLE next cycle, no out_valid.
REQ-030 Scenario reset and restart: rst_n low mid-ACC -> all outputs 0 asynchronously; start num_ops=1, beat (0x0005,0xAAAA) -> out_sum=0x000005.

Source files
------------

// File: rtl/mop_sum_ctrl.sv
// Multi-operand summing controller: a job of num_ops operands arrives as
// ceil(num_ops/2) beats of operand pairs, the pairs are summed into one
// accumulator, and the total is held on a valid/ready result port.
module mop_sum_ctrl #(
    parameter int unsigned W  = 16,
    parameter int unsigned NW = 8,
    parameter int unsigned AW = W + NW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num_ops,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [NW-1:0] rem_q, rem_d;
    logic          err_q, err_d;

    // Decoded events used by both the FSM and the datapath
    logic          job_start;
    logic          job_reject;
    logic          beat;
    logic          last_beat;
    logic          drain;
    logic [AW-1:0] opnd_a;
    logic [AW-1:0] opnd_b;

    // Event decode: start only counts in idle, beats only in accumulate
    always_comb begin
        job_start  = (state_q == StIdle) && start && (num_ops != '0);
        job_reject = (state_q == StIdle) && start && (num_ops == '0);
        beat       = (state_q == StAcc) && in_valid;
        // rem of 1 or 2 means this beat carries the final operand(s)
        last_beat  = beat && (rem_q <= NW'(2));
        drain      = (state_q == StDone) && out_ready;
        opnd_a     = AW'(in_a);
        // An odd job's final beat carries only one real operand
        opnd_b     = (rem_q == NW'(1)) ? '0 : AW'(in_b);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every other transition
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (job_start) state_d = StAcc;
                StAcc:  if (last_beat) state_d = StDone;
                StDone: if (drain)     state_d = StIdle;
                default:               state_d = StIdle;
            endcase
        end
    end

    // Output decode: all outputs come from state or registers only
    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_sum   = (state_q == StDone) ? acc_q : '0;
        err       = err_q;
    end

    // Datapath next state: accumulator, remaining-operand count, error pulse
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        err_d = 1'b0;
        if (clear) begin
            acc_d = '0;
            rem_d = '0;
        end else if (job_start) begin
            acc_d = '0;
            rem_d = num_ops;
        end else if (job_reject) begin
            err_d = 1'b1;
        end else if (beat) begin
            // Single three-operand add; AW is wide enough that it never wraps
            acc_d = acc_q + opnd_a + opnd_b;
            rem_d = last_beat ? '0 : rem_q - NW'(2);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            err_q <= err_d;
        end
    end

endmodule
